// File: rtl/memory_access_pkg.sv
// Shared types for the memory-access pipeline stage: pipe records, data-bus
// request/response, access-size encoding and misalignment cause codes.
package memory_access_pkg;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    localparam logic [63:0] MCAUSE_LOAD_MISALIGNED  = 64'd4;
    localparam logic [63:0] MCAUSE_STORE_MISALIGNED = 64'd6;

    // memext = 1 selects sign extension of load data
    typedef struct packed {
        logic   memread;
        logic   memwrite;
        msize_t memsize;
        logic   memext;
        logic   regwrite;
    } control_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] mcause;
        logic [63:0] mtval;
    } excep_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        control_t    ctl;
        logic [4:0]  dst;
        logic [63:0] aluout;
        logic [63:0] memwd;
    } execute_data_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        control_t    ctl;
        logic [4:0]  dst;
        logic [63:0] result;
        excep_t      excep;
    } memory_data_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic logic [7:0] size_mask(input msize_t size);
        logic [7:0] m;
        case (size)
            MSIZE1:  m = 8'h01;
            MSIZE2:  m = 8'h03;
            MSIZE4:  m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/memory_access_if.sv
// Pipeline and data-bus signals of the memory-access stage.
// master = the stage itself, slave = surrounding pipeline and bus.
interface memory_access_if;
    import memory_access_pkg::*;

    execute_data_t dataE;
    logic          mem_misaligned;
    logic [63:0]   mem_mcause;
    logic          flush;
    logic          stallM;
    dbus_req_t     dreq;
    dbus_resp_t    dresp;
    memory_data_t  dataM;
    logic          skip;

    modport master (
        input  dataE, mem_misaligned, mem_mcause, flush, dresp,
        output stallM, dreq, dataM, skip
    );

    modport slave (
        output dataE, mem_misaligned, mem_mcause, flush, dresp,
        input  stallM, dreq, dataM, skip
    );

endinterface

// File: rtl/memory_access_readdata.sv
// Load lane extraction: shifts the addressed bytes down to bit 0 and
// truncates/extends them to the access size.
module memory_access_readdata
    import memory_access_pkg::*;
(
    input  logic [2:0]  addr_i,
    input  msize_t      size_i,
    input  logic        ext_i,
    input  logic [63:0] raw_i,
    output logic [63:0] word_o
);

    logic [63:0] shifted;

    always_comb begin
        shifted = raw_i >> {addr_i, 3'b000};
        word_o  = shifted;
        case (size_i)
            MSIZE1:  word_o = ext_i ? {{56{shifted[7]}},  shifted[7:0]}  : {56'b0, shifted[7:0]};
            MSIZE2:  word_o = ext_i ? {{48{shifted[15]}}, shifted[15:0]} : {48'b0, shifted[15:0]};
            MSIZE4:  word_o = ext_i ? {{32{shifted[31]}}, shifted[31:0]} : {32'b0, shifted[31:0]};
            default: word_o = shifted;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// Memory-access pipeline stage: issues one data-bus access per load/store and
// hands results to writeback. MEM_MMIO_SKIP_EN enables the MMIO difftest skip.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no access outstanding; dataE accepted or passed through
// ST_BUSY  | bus access pending; result goes to dataM on data_ok
// ST_DRAIN | flushed access still on the bus; result dropped on data_ok
module memory_access
    import memory_access_pkg::*;
#(
    parameter int SKIP_ADDR_BIT = 31
) (
    input logic             clk,
    input logic             reset,
    memory_access_if.master bus
);

    state_t        state_q, state_d;
    execute_data_t inst_q, inst_d;
    memory_data_t  data_m_q, data_m_d;
    dbus_req_t     dreq_q, dreq_d;
    logic [63:0]   load_word;
    logic [2:0]    off_e;
    logic          accept_e;

    memory_access_readdata u_readdata (
        .addr_i (inst_q.aluout[2:0]),
        .size_i (inst_q.ctl.memsize),
        .ext_i  (inst_q.ctl.memext),
        .raw_i  (bus.dresp.data),
        .word_o (load_word)
    );

    assign off_e    = bus.dataE.aluout[2:0];
    assign accept_e = bus.dataE.valid && (bus.dataE.ctl.memread || bus.dataE.ctl.memwrite)
                      && !bus.mem_misaligned && !bus.flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            inst_q   <= '0;
            data_m_q <= '0;
            dreq_q   <= '0;
        end else begin
            state_q  <= state_d;
            inst_q   <= inst_d;
            data_m_q <= data_m_d;
            dreq_q   <= dreq_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        inst_d     = inst_q;
        data_m_d   = '0;
        dreq_d     = dreq_q;
        bus.stallM = 1'b0;
        case (state_q)
            ST_IDLE: begin
                dreq_d = '0;
                if (accept_e) begin
                    state_d       = ST_BUSY;
                    inst_d        = bus.dataE;
                    bus.stallM    = 1'b1;
                    dreq_d.valid  = 1'b1;
                    dreq_d.addr   = bus.dataE.aluout;
                    dreq_d.size   = bus.dataE.ctl.memsize;
                    dreq_d.strobe = bus.dataE.ctl.memwrite ? (size_mask(bus.dataE.ctl.memsize) << off_e) : 8'h00;
                    dreq_d.data   = bus.dataE.ctl.memwrite ? (bus.dataE.memwd << {off_e, 3'b000}) : 64'h0;
                end else if (bus.dataE.valid && !bus.flush) begin
                    data_m_d.valid  = 1'b1;
                    data_m_d.pc     = bus.dataE.pc;
                    data_m_d.ctl    = bus.dataE.ctl;
                    data_m_d.dst    = bus.dataE.dst;
                    data_m_d.result = bus.dataE.aluout;
                    if (bus.mem_misaligned) begin
                        data_m_d.excep.valid  = 1'b1;
                        data_m_d.excep.mcause = bus.mem_mcause;
                        data_m_d.excep.mtval  = bus.dataE.aluout;
                        data_m_d.ctl.regwrite = 1'b0;
                        data_m_d.ctl.memwrite = 1'b0;
                    end
                end
            end
            ST_BUSY: begin
                bus.stallM = !bus.dresp.data_ok;
                if (bus.dresp.data_ok) begin
                    state_d = ST_IDLE;
                    dreq_d  = '0;
                    if (!bus.flush) begin
                        data_m_d.valid  = inst_q.valid;
                        data_m_d.pc     = inst_q.pc;
                        data_m_d.ctl    = inst_q.ctl;
                        data_m_d.dst    = inst_q.dst;
                        data_m_d.result = inst_q.ctl.memread ? load_word : inst_q.aluout;
                    end
                end else if (bus.flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                bus.stallM = !bus.dresp.data_ok;
                if (bus.dresp.data_ok) begin
                    state_d = ST_IDLE;
                    dreq_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                dreq_d  = '0;
            end
        endcase
        if (reset) bus.stallM = 1'b0;
    end

    assign bus.dreq  = dreq_q;
    assign bus.dataM = data_m_q;

    // memwd is consumed when the request is built; addr_ok is not needed
    // because the request is held until data_ok anyway
    logic unused_ok;
    assign unused_ok = ^{bus.dresp.addr_ok, inst_q.memwd};

`ifdef MEM_MMIO_SKIP_EN
    logic skip_q, skip_d;
    assign skip_d = data_m_d.valid && (state_q != ST_IDLE) && !inst_q.aluout[SKIP_ADDR_BIT];
    always_ff @(posedge clk) begin
        if (reset) skip_q <= 1'b0;
        else       skip_q <= skip_d;
    end
    assign bus.skip = skip_q;
`else
    logic unused_skip_bit;
    assign unused_skip_bit = inst_q.aluout[SKIP_ADDR_BIT];
    assign bus.skip        = 1'b0;
`endif

endmodule

// File: tb/tb_memory_access.sv
// Randomized and directed checks of memory_access against a byte-level model.
module tb_memory_access;
    import memory_access_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    memory_access_if bus_if();

    memory_access #(.SKIP_ADDR_BIT(31)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // byte-level reference: pick nbytes starting at lane off, then extend
    function automatic logic [63:0] ref_load(input logic [63:0] raw, input int off, input int nbytes, input bit sgn);
        logic [63:0] v = 64'h0;
        for (int i = 0; i < nbytes; i++) v[8*i +: 8] = raw[8*(off+i) +: 8];
        if (sgn && v[8*nbytes-1])
            for (int i = nbytes; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [7:0] ref_strobe(input int off, input int nbytes);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < nbytes; i++) if (off + i < 8) s[off+i] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] ref_wdata(input logic [63:0] wd, input int off);
        logic [63:0] d = 64'h0;
        for (int j = off; j < 8; j++) d[8*j +: 8] = wd[8*(j-off) +: 8];
        return d;
    endfunction

    // fmode: 0 none, 1 flush with the incoming instruction, 2 flush in first BUSY cycle
    task automatic run_inst(input string nm, input bit rd, input bit wr, input int sz, input bit ext,
                            input logic [63:0] addr, input logic [63:0] wd, input bit mis,
                            input int lat, input int fmode, input logic [63:0] raw);
        int          nbytes = 1 << sz;
        int          off    = int'(addr[2:0]);
        bit          mem_go;
        bit          exp_valid;
        bit          exp_skip;
        int          stall_cnt;
        logic [63:0] pc     = {$urandom, $urandom};
        logic [4:0]  dst    = 5'($urandom);
        logic [63:0] exp_res;

        @(negedge clk);
        bus_if.dataE              = '0;
        bus_if.dataE.valid        = 1'b1;
        bus_if.dataE.pc           = pc;
        bus_if.dataE.dst          = dst;
        bus_if.dataE.ctl.memread  = rd;
        bus_if.dataE.ctl.memwrite = wr;
        bus_if.dataE.ctl.memsize  = msize_t'(sz);
        bus_if.dataE.ctl.memext   = ext;
        bus_if.dataE.ctl.regwrite = !wr;
        bus_if.dataE.aluout       = addr;
        bus_if.dataE.memwd        = wd;
        bus_if.mem_misaligned     = mis;
        bus_if.mem_mcause         = wr ? 64'd6 : 64'd4;
        bus_if.flush              = (fmode == 1);
        bus_if.dresp              = '0;
        #1;
        mem_go = (rd || wr) && !mis && (fmode != 1);
        check_eq({nm, ":stall_accept"}, 64'(bus_if.stallM), 64'(mem_go));
        check_eq({nm, ":dreq_idle"}, 64'(bus_if.dreq.valid), 64'h0);
        stall_cnt = int'(bus_if.stallM);
        @(posedge clk);
        if (mem_go) begin
            for (int n = 1; n <= lat; n++) begin
                @(negedge clk);
                bus_if.flush         = (fmode == 2) && (n == 1);
                bus_if.dresp.data_ok = (n == lat);
                bus_if.dresp.data    = (n == lat) ? raw : {$urandom, $urandom};
                #1;
                check_eq({nm, ":dreq_valid"}, 64'(bus_if.dreq.valid), 64'h1);
                check_eq({nm, ":dreq_addr"}, bus_if.dreq.addr, addr);
                check_eq({nm, ":dreq_size"}, 64'(bus_if.dreq.size), 64'(sz));
                check_eq({nm, ":dreq_strobe"}, 64'(bus_if.dreq.strobe), wr ? 64'(ref_strobe(off, nbytes)) : 64'h0);
                if (wr) check_eq({nm, ":dreq_data"}, bus_if.dreq.data, ref_wdata(wd, off));
                check_eq({nm, ":stall_busy"}, 64'(bus_if.stallM), 64'(n != lat));
                check_eq({nm, ":no_early_result"}, 64'(bus_if.dataM.valid), 64'h0);
                stall_cnt += int'(bus_if.stallM);
                @(posedge clk);
            end
        end
        @(negedge clk);
        bus_if.dataE.valid = 1'b0;
        bus_if.flush       = 1'b0;
        bus_if.dresp       = '0;
        #1;
        exp_valid = (fmode == 0) || (fmode == 2 && !mem_go);
        check_eq({nm, ":dataM_valid"}, 64'(bus_if.dataM.valid), 64'(exp_valid));
        if (exp_valid) begin
            exp_res = (rd && !mis) ? ref_load(raw, off, nbytes, ext) : addr;
            check_eq({nm, ":result"}, bus_if.dataM.result, exp_res);
            check_eq({nm, ":pc"}, bus_if.dataM.pc, pc);
            check_eq({nm, ":dst"}, 64'(bus_if.dataM.dst), 64'(dst));
            check_eq({nm, ":excep"}, 64'(bus_if.dataM.excep.valid), 64'(mis));
            check_eq({nm, ":regwrite"}, 64'(bus_if.dataM.ctl.regwrite), 64'(!wr && !mis));
            if (mis) begin
                check_eq({nm, ":mcause"}, bus_if.dataM.excep.mcause, wr ? 64'd6 : 64'd4);
                check_eq({nm, ":mtval"}, bus_if.dataM.excep.mtval, addr);
            end
        end
`ifdef MEM_MMIO_SKIP_EN
        exp_skip = exp_valid && mem_go && !addr[31];
`else
        exp_skip = 1'b0;
`endif
        check_eq({nm, ":skip"}, 64'(bus_if.skip), 64'(exp_skip));
        check_eq({nm, ":dreq_after"}, 64'(bus_if.dreq.valid), 64'h0);
        check_eq({nm, ":stall_after"}, 64'(bus_if.stallM), 64'h0);
        if (mem_go) check_eq({nm, ":stall_cycles"}, 64'(stall_cnt), 64'(lat));
        @(negedge clk);
        #1;
        check_eq({nm, ":single_result"}, 64'(bus_if.dataM.valid), 64'h0);
    endtask

    initial begin
        reset                 = 1'b1;
        bus_if.dataE          = '0;
        bus_if.dataE.valid    = 1'b1;
        bus_if.dataE.ctl.memread = 1'b1;
        bus_if.mem_misaligned = 1'b0;
        bus_if.mem_mcause     = '0;
        bus_if.flush          = 1'b0;
        bus_if.dresp          = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("reset:stall", 64'(bus_if.stallM), 64'h0);
        check_eq("reset:dreq", 64'(bus_if.dreq), 64'h0);
        check_eq("reset:dataM_valid", 64'(bus_if.dataM.valid), 64'h0);
        check_eq("reset:dataM_result", bus_if.dataM.result, 64'h0);
        check_eq("reset:skip", 64'(bus_if.skip), 64'h0);
        bus_if.dataE.valid = 1'b0;
        reset = 1'b0;

        run_inst("sd",      0, 1, 3, 0, 64'h8000_1008, 64'h1122_3344_5566_7788, 0, 3, 0, 64'h0);
        run_inst("lb",      1, 0, 0, 1, 64'h8000_0003, 64'h0, 0, 2, 0, 64'h0000_0000_8000_0000);
        run_inst("lbu",     1, 0, 0, 0, 64'h8000_0003, 64'h0, 0, 1, 0, 64'h0000_0000_8000_0000);
        run_inst("sh",      0, 1, 1, 0, 64'h8000_0002, 64'h0000_0000_0000_ABCD, 0, 2, 0, 64'h0);
        run_inst("lw_mis",  1, 0, 2, 1, 64'h8000_0002, 64'h0, 1, 1, 0, 64'h0);
        run_inst("ld_fl",   1, 0, 3, 0, 64'h8000_0010, 64'h0, 0, 5, 2, 64'hDEAD_BEEF_0123_4567);
        run_inst("ld_fl0",  1, 0, 3, 0, 64'h8000_0018, 64'h0, 0, 2, 1, 64'h0);
        run_inst("alu",     0, 0, 0, 0, 64'h1234_5678_9ABC_DEF0, 64'h0, 0, 1, 0, 64'h0);
        run_inst("lw_mmio", 1, 0, 2, 1, 64'h4000_0000, 64'h0, 0, 1, 0, 64'h0000_0000_8765_4321);
        run_inst("lw_mem",  1, 0, 2, 1, 64'h8000_0000, 64'h0, 0, 1, 0, 64'h0000_0000_8765_4321);

        // reset while an access is pending drops the request at once
        @(negedge clk);
        bus_if.dataE              = '0;
        bus_if.dataE.valid        = 1'b1;
        bus_if.dataE.ctl.memread  = 1'b1;
        bus_if.dataE.ctl.memsize  = MSIZE8;
        bus_if.dataE.aluout       = 64'h8000_0100;
        @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_busy:dreq_before", 64'(bus_if.dreq.valid), 64'h1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        bus_if.dataE.valid = 1'b0;
        #1;
        check_eq("rst_busy:dreq_after", 64'(bus_if.dreq.valid), 64'h0);
        check_eq("rst_busy:stall_after", 64'(bus_if.stallM), 64'h0);
        check_eq("rst_busy:dataM", 64'(bus_if.dataM.valid), 64'h0);
        run_inst("after_rst", 1, 0, 2, 0, 64'h8000_0104, 64'h0, 0, 2, 0, 64'hCAFE_F00D_1357_9BDF);

        for (int k = 0; k < 80; k++) begin
            int          kind  = int'($urandom_range(0, 5));
            int          sz    = int'($urandom_range(0, 3));
            bit          rd    = (kind == 1 || kind == 2 || kind == 3);
            bit          wr    = (kind == 4 || kind == 5);
            bit          mis   = (rd || wr) && ($urandom_range(0, 7) == 0);
            int          fmode = int'($urandom_range(0, 9));
            logic [63:0] addr  = {32'h0, ($urandom_range(0, 1) != 0) ? 1'b1 : 1'b0, 31'($urandom)};
            addr  = mis ? addr : (addr & ~64'((1 << sz) - 1));
            fmode = (fmode == 0) ? 1 : ((fmode == 1 && (rd || wr) && !mis) ? 2 : 0);
            run_inst("rand", rd, wr, sz, $urandom_range(0, 1) != 0, addr, {$urandom, $urandom},
                     mis, int'($urandom_range(1, 6)), fmode, {$urandom, $urandom});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
